// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if
//   Groups the decode/execute-side signals of the hazard scoreboard into one bundle.
//   master : pipeline side. Drives the D-stage instruction description and the E-stage
//            resolution signals. Receives the stall, flush and forwarding controls and
//            the performance counters.
//   slave  : the scoreboard itself (the mirror image of master).
//   Signals:
//     d_valid, d_src_addr, d_src_used, d_wr_en, d_wa, d_is_load, d_pc_wr
//         Describe the instruction currently in D. Operand i of d_src_addr sits at
//         [i*REG_AW +: REG_AW].
//     e_cond_pass, e_branch_taken
//         E-stage condition check result and taken-branch resolution.
//     clr_cnt
//         Synchronous clear of both performance counters.
//     stall_f, stall_d, flush_d, flush_e
//         Pipeline controls.
//     fwd_sel
//         Per E operand: 0 = register file, k = result held in scoreboard slot k.
//     stall_cnt, flush_cnt
//         Saturating performance counters.
interface hazard_scoreboard_if #(
  parameter int REG_AW  = 4,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16,
  parameter int SEL_W   = 2
);
  logic                      d_valid;
  logic [NUM_SRC*REG_AW-1:0] d_src_addr;
  logic [NUM_SRC-1:0]        d_src_used;
  logic                      d_wr_en;
  logic [REG_AW-1:0]         d_wa;
  logic                      d_is_load;
  logic                      d_pc_wr;
  logic                      e_cond_pass;
  logic                      e_branch_taken;
  logic                      clr_cnt;
  logic                      stall_f;
  logic                      stall_d;
  logic                      flush_d;
  logic                      flush_e;
  logic [NUM_SRC*SEL_W-1:0]  fwd_sel;
  logic [CNT_W-1:0]          stall_cnt;
  logic [CNT_W-1:0]          flush_cnt;

  modport master (
    output d_valid, d_src_addr, d_src_used, d_wr_en, d_wa, d_is_load, d_pc_wr,
    output e_cond_pass, e_branch_taken, clr_cnt,
    input  stall_f, stall_d, flush_d, flush_e, fwd_sel, stall_cnt, flush_cnt
  );

  modport slave (
    input  d_valid, d_src_addr, d_src_used, d_wr_en, d_wa, d_is_load, d_pc_wr,
    input  e_cond_pass, e_branch_taken, clr_cnt,
    output stall_f, stall_d, flush_d, flush_e, fwd_sel, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Hazard and forwarding controller for the in-order pipelined core.
//   Every in-flight register writer after Decode sits in a shift-register scoreboard:
//   slot 0 is E and slot DEPTH-1 is W. From that state the block derives:
//     - the load-use stall,
//     - the PC-write and branch flushes,
//     - the per-operand forwarding selects.
//   It also keeps two saturating performance counters.
//   Ports:
//     clk : clock.
//     rst : synchronous, active-high reset. All hazard outputs read 0 while it is high.
//     bus : hazard_scoreboard_if.slave, carrying the D/E inputs, the controls and the
//           counters.
module hazard_scoreboard #(
  parameter int REG_AW   = 4,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int NUM_SRC  = 2,
  parameter int CNT_W    = 16,
  parameter int SEL_W    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  hazard_scoreboard_if.slave bus
);

  localparam logic [REG_AW-1:0] PC_REG = '1;
  localparam int                AV_W   = $clog2(DEPTH + 1);
  // avail = first slot index+1 at which the result can be forwarded
  localparam logic [AV_W-1:0] AVAIL_LOAD = AV_W'(1 + LOAD_LAT);
  localparam logic [AV_W-1:0] AVAIL_ALU  = AV_W'(1);

  // Scoreboard state
  logic [DEPTH-1:0]  slotValid;
  logic [DEPTH-1:0]  slotWrEn;
  logic [DEPTH-1:0]  slotPcWr;
  logic [REG_AW-1:0] slotWa    [DEPTH];
  // The W slot never gates a stall, so avail is only kept for slots 0..DEPTH-2
  logic [AV_W-1:0]   slotAvail [DEPTH-1];
  // Source operands of the instruction in E (slot 0 only)
  logic [REG_AW-1:0]  eSrcAddr [NUM_SRC];
  logic [NUM_SRC-1:0] eSrcUsed;

  logic [CNT_W-1:0] stallCnt;
  logic [CNT_W-1:0] flushCnt;

  // Combinational hazard terms
  logic [REG_AW-1:0]        dSrc [NUM_SRC];
  logic                     dHit [NUM_SRC][DEPTH-1];
  logic                     eHit [NUM_SRC][1:DEPTH-1];
  logic [NUM_SRC-1:0]       srcLate;
  logic                     ldrStall;
  logic                     pcPending;
  logic                     flushE;
  logic                     flushD;
  logic                     s0Valid;
  logic [NUM_SRC*SEL_W-1:0] fwdFlat;

  // Match matrices: D operands against slots 0..DEPTH-2 (stall check), and E operands
  // against slots 1..DEPTH-1 (forwarding). Reads of the PC never match because the PC
  // value is supplied by the fetch path, not by the forwarding network.
  genvar gi, gk;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign dSrc[gi] = bus.d_src_addr[gi*REG_AW +: REG_AW];

      for (gk = 0; gk < DEPTH - 1; gk++) begin : g_dhit
        assign dHit[gi][gk] = slotValid[gk] & slotWrEn[gk] &
                              (slotWa[gk] == dSrc[gi]) & (dSrc[gi] != PC_REG) &
                              bus.d_src_used[gi];
      end

      for (gk = 1; gk < DEPTH; gk++) begin : g_ehit
        assign eHit[gi][gk] = slotValid[gk] & slotWrEn[gk] &
                              (slotWa[gk] == eSrcAddr[gi]) & (eSrcAddr[gi] != PC_REG) &
                              eSrcUsed[gi];
      end
    end
  endgenerate

  // Walk from oldest to youngest so that the youngest matching writer decides.
  always_comb begin
    srcLate = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = DEPTH - 2; k >= 0; k--) begin
        if (dHit[i][k]) begin
          srcLate[i] = ((k + 1) < int'(slotAvail[k]));
        end
      end
    end
    ldrStall = |srcLate;
  end

  always_comb begin
    fwdFlat = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        if (eHit[i][k]) begin
          fwdFlat[i*SEL_W +: SEL_W] = SEL_W'(k);
        end
      end
    end
  end

  // A PC writer blocks fetch until it reaches W. The W-stage write itself only needs
  // one more D flush.
  assign pcPending = (bus.d_valid & bus.d_pc_wr) | (|slotPcWr[DEPTH-2:0]);
  assign flushE    = ldrStall | bus.e_branch_taken;
  assign flushD    = pcPending | slotPcWr[DEPTH-1] | bus.e_branch_taken;
  assign s0Valid   = bus.d_valid & ~flushE;

  // Control flags shift with reset. A condition failure in E cancels the write as the
  // instruction leaves E.
  always_ff @(posedge clk) begin
    if (rst) begin
      slotValid <= '0;
      slotWrEn  <= '0;
      slotPcWr  <= '0;
      eSrcUsed  <= '0;
    end else begin
      slotValid[0] <= s0Valid;
      slotWrEn[0]  <= s0Valid & bus.d_wr_en;
      slotPcWr[0]  <= s0Valid & bus.d_pc_wr;
      eSrcUsed     <= s0Valid ? bus.d_src_used : '0;
      slotValid[1] <= slotValid[0];
      slotWrEn[1]  <= slotWrEn[0] & bus.e_cond_pass;
      slotPcWr[1]  <= slotPcWr[0] & bus.e_cond_pass;
      for (int k = 2; k < DEPTH; k++) begin
        slotValid[k] <= slotValid[k-1];
        slotWrEn[k]  <= slotWrEn[k-1];
        slotPcWr[k]  <= slotPcWr[k-1];
      end
    end
  end

  // Payload fields are qualified by the flags above, so they need no reset.
  always_ff @(posedge clk) begin
    slotWa[0]    <= bus.d_wa;
    slotAvail[0] <= bus.d_is_load ? AVAIL_LOAD : AVAIL_ALU;
    for (int k = 1; k < DEPTH; k++) begin
      slotWa[k] <= slotWa[k-1];
    end
    for (int k = 1; k < DEPTH - 1; k++) begin
      slotAvail[k] <= slotAvail[k-1];
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      eSrcAddr[i] <= dSrc[i];
    end
  end

  // Saturating counters. A clear takes priority over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || bus.clr_cnt) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (ldrStall && !(&stallCnt)) begin
        stallCnt <= stallCnt + CNT_W'(1);
      end
      if (flushD && !(&flushCnt)) begin
        flushCnt <= flushCnt + CNT_W'(1);
      end
    end
  end

  assign bus.stall_f   = ~rst & (ldrStall | pcPending);
  assign bus.stall_d   = ~rst & ldrStall;
  assign bus.flush_d   = ~rst & flushD;
  assign bus.flush_e   = ~rst & flushE;
  assign bus.fwd_sel   = rst ? '0 : fwdFlat;
  assign bus.stall_cnt = stallCnt;
  assign bus.flush_cnt = flushCnt;

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard and forwarding controller for the in-order pipelined ARM core.
- Tracks every in-flight register writer in a shift-register scoreboard, one slot per stage after Decode. Slot 0 = E, slot DEPTH-1 = W.
- From the scoreboard it generates stall, flush and forwarding selects for any pipeline depth, load latency and source-operand count.
- Also keeps saturating stall/flush performance counters.

Parameters:
- REG_AW, 4, register address width; register 2**REG_AW-1 is the PC.
- DEPTH, 3, scoreboard slots (stages E..W); must be >= 3.
- LOAD_LAT, 1, extra stages before load data is forwardable; 1+LOAD_LAT <= DEPTH-1.
- NUM_SRC, 2, source operands per instruction.
- CNT_W, 16, performance counter width.
- SEL_W, $clog2(DEPTH), forwarding select width (derived).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- d_valid  in  1  real instruction in D.
- d_src_addr  in  NUM_SRC*REG_AW  D source registers; operand i at bits [i*REG_AW +: REG_AW].
- d_src_used  in  NUM_SRC  per-operand read enable.
- d_wr_en  in  1  D instruction writes a register.
- d_wa  in  REG_AW  D destination register.
- d_is_load  in  1  D result comes from memory.
- d_pc_wr  in  1  D instruction writes the PC.
- e_cond_pass  in  1  E-stage condition check passed.
- e_branch_taken  in  1  branch resolved taken in E.
- clr_cnt  in  1  synchronous counter clear.
- stall_f  out  1  hold the PC.
- stall_d  out  1  hold the D register.
- flush_d  out  1  load a NOP into D.
- flush_e  out  1  load a bubble into E.
- fwd_sel  out  NUM_SRC*SEL_W  per E operand: 0 = regfile, k = result of slot k.
- stall_cnt  out  CNT_W  cycles with stall_d=1.
- flush_cnt  out  CNT_W  cycles with flush_d=1.

Behaviour:
- Slot contents: valid, wr_en, wa, avail, pc_wr, and (slot 0 only) src_addr/src_used.
  - avail = 1+LOAD_LAT for loads, else 1.
- Every cycle slots shift k -> k+1; slot DEPTH-1 retires.
- Slot 0 input:
  - Bubble (valid=0) if flush_e=1.
  - Otherwise the D instruction, with valid=d_valid.
- On the slot 0 -> 1 transfer, wr_en and pc_wr are ANDed with e_cond_pass.
- Match rule: only slots with valid & wr_en match.
  - wa equal to the source address.
  - Source address is not the PC register.
  - d_src_used (or stored src_used) set.
  - "Youngest" = lowest slot index.
- Load-use stall (ldr_stall):
  - For any used D source, take the youngest matching slot k in 0..DEPTH-2.
  - Stall when k+1 < avail.
  - Slot DEPTH-1 is ignored; the regfile writes on the falling edge, so D reads the new value.
- fwd_sel[i]:
  - Youngest matching slot k in 1..DEPTH-1 for E operand i, else 0.
  - Combinational from registered state only.
- pc_pending = (d_valid & d_pc_wr) | pc_wr of any slot 0..DEPTH-2.
- Control outputs:
  - stall_f = ldr_stall | pc_pending.
  - stall_d = ldr_stall.
  - flush_d = pc_pending | slot[DEPTH-1].pc_wr | e_branch_taken.
  - flush_e = ldr_stall | e_branch_taken.
- Simultaneous ldr_stall and e_branch_taken: flush wins; one bubble, counted as a stall.
- Counters:
  - Increment on stall_d / flush_d.
  - Saturate at all-ones, never wrap.
  - clr_cnt zeroes them; clear wins over increment in the same cycle.
- Reset:
  - All slots invalid, counters 0.
  - While rst=1, stall_f, stall_d, flush_e, flush_d and fwd_sel are 0, regardless of the D inputs.
  - Reset mid-stall or mid-PC-write drops all pending hazards on the next cycle.
- Latency: all hazard outputs are combinational in the same cycle; scoreboard state is updated at the posedge.

Test Plan:
1. Reset with d_valid=1, d_wr_en=1 held 2 cycles -> all control outputs 0, fwd_sel=0, counters 0 on the cycle after release.
2. ADD R1 then SUB reading R1 (src0), then ORR reading R1 (src0) -> no stall; SUB in E has fwd_sel[0]=1; ORR in E has fwd_sel[0]=2.
3. LDR R2 then ADD reading R2 (src1) -> stall_d=stall_f=flush_e=1 for exactly 1 cycle; ADD in E has fwd_sel[1]=2; stall_cnt=1.
4. ADD R3; SUB R3; ORR reading R3 -> fwd_sel[0]=1 (youngest writer); ADD R4 with e_cond_pass=0 then a reader of R4 -> fwd_sel=0; reads of R15 -> no stall, fwd_sel=0.
5. LDR PC (d_pc_wr=1, cond passes) -> stall_f high 3 cycles, flush_d high 4 cycles, flush_cnt=4; e_branch_taken pulse -> flush_d=flush_e=1 in the same cycle.
6. Force stall_cnt to all-ones (CNT_W=4, 16 load-use stalls) -> holds 15; clr_cnt during a stall -> 0.
